// File: rtl/sprite_compositor.sv
// Multi-sprite compositor: frame-shadowed sprite attributes, priority mixing over
// the background, full-screen overlay and per-frame player collision flags.
module sprite_compositor #(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_W       = 20,
  parameter int SPR_H       = 24,
  parameter int ADDR_W      = 13,
  parameter int TRANSP      = 0
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  input  logic [10*NUM_SPRITES-1:0]     spr_x,
  input  logic [10*NUM_SPRITES-1:0]     spr_y,
  input  logic [NUM_SPRITES-1:0]        spr_en,
  input  logic [NUM_SPRITES-1:0]        spr_flip,
  output logic [ADDR_W*NUM_SPRITES-1:0] rom_addr,
  input  logic [4*NUM_SPRITES-1:0]      rom_data,
  input  logic [3:0]                    bg_idx,
  input  logic                          overlay_en,
  input  logic [3:0]                    overlay_idx,
  output logic [3:0]                    color_idx,
  output logic [NUM_SPRITES-1:0]        collide
);

  localparam int N = NUM_SPRITES;
  localparam logic [3:0] TRANSP_IDX = 4'(TRANSP);

  logic           at_origin;
  logic           frame_seen;
  logic           fs;
  logic [10*N-1:0] sx_q;
  logic [10*N-1:0] sy_q;
  logic [N-1:0]   sen_q;
  logic [N-1:0]   sflip_q;
  logic [N-1:0]   hit;
  logic [10:0]    px;
  logic [10:0]    py;

  assign at_origin = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign fs        = at_origin && !frame_seen;
  assign px        = {1'b0, DrawX};
  assign py        = {1'b0, DrawY};

  // Attributes are latched once per frame so software writes never tear a frame
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_seen <= 1'b0;
      sx_q       <= '0;
      sy_q       <= '0;
      sen_q      <= '0;
      sflip_q    <= '0;
    end else begin
      frame_seen <= at_origin;
      if (fs) begin
        sx_q    <= spr_x;
        sy_q    <= spr_y;
        sen_q   <= spr_en;
        sflip_q <= spr_flip;
      end
    end
  end

  // Stage 0: hit test and ROM addressing (11-bit compares keep right edges past 1023 from wrapping)
  for (genvar g = 0; g < N; g++) begin : g_spr
    logic [10:0]       x0;
    logic [10:0]       y0;
    logic [9:0]        dx;
    logic [9:0]        dy;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] lin;

    assign x0 = {1'b0, sx_q[10*g +: 10]};
    assign y0 = {1'b0, sy_q[10*g +: 10]};
    assign hit[g] = sen_q[g] && (px >= x0) && (px < x0 + 11'(SPR_W)) &&
                    (py >= y0) && (py < y0 + 11'(SPR_H));
    assign dx  = DrawX - sx_q[10*g +: 10];
    assign dy  = DrawY - sy_q[10*g +: 10];
    assign col = sflip_q[g] ? ADDR_W'(SPR_W - 1) - ADDR_W'(dx) : ADDR_W'(dx);
    assign lin = ADDR_W'(dy) * ADDR_W'(SPR_W) + col;
    assign rom_addr[ADDR_W*g +: ADDR_W] = hit[g] ? lin : '0;
  end

  // Stage 1: align side-band data with the synchronous ROM read
  logic [N-1:0] hit_p1;
  logic [3:0]   bg_p1;
  logic [3:0]   ov_idx_p1;
  logic         ov_en_p1;
  logic         fs_p1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hit_p1    <= '0;
      bg_p1     <= '0;
      ov_idx_p1 <= '0;
      ov_en_p1  <= 1'b0;
      fs_p1     <= 1'b0;
    end else begin
      hit_p1    <= hit;
      bg_p1     <= bg_idx;
      ov_idx_p1 <= overlay_idx;
      ov_en_p1  <= overlay_en;
      fs_p1     <= fs;
    end
  end

  // Stage 2: priority mix, overlay and collision accumulation
  logic [N-1:0] op;
  logic [N-1:0] contrib;
  logic [N-1:0] acc_q;
  logic [3:0]   color_nxt;

  always_comb begin
    op        = '0;
    contrib   = '0;
    color_nxt = bg_p1;
    // Walk from the highest index down so the lowest opaque sprite wins
    for (int i = N - 1; i >= 0; i--) begin
      op[i] = hit_p1[i] && (rom_data[4*i +: 4] != TRANSP_IDX);
      if (op[i]) color_nxt = rom_data[4*i +: 4];
    end
    for (int i = 1; i < N; i++) contrib[i] = op[0] && op[i];
    if (ov_en_p1 && (ov_idx_p1 != TRANSP_IDX)) color_nxt = ov_idx_p1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      color_idx <= '0;
      collide   <= '0;
      acc_q     <= '0;
    end else begin
      color_idx <= color_nxt;
      // The frame-start pixel itself still belongs to the frame being closed
      if (fs_p1) begin
        collide <= acc_q | contrib;
        acc_q   <= '0;
      end else begin
        acc_q   <= acc_q | contrib;
      end
    end
  end

endmodule
